// File: rtl/vfxp_round_wb.sv
// Writeback stage for averaging-add results: per-element vxrm rounding,
// then a small FIFO feeding the vector register-file write port.
module vfxp_round_wb #(
    parameter int DATA_WIDTH    = 64,
    parameter int BE_WIDTH      = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter bit ENABLE_64_BIT = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_vec,
    input  logic [ADDR_WIDTH-1:0]         in_addr,
    input  logic [BE_WIDTH-1:0]           in_be,
    input  logic                          in_mask,
    input  logic                          in_fxp,
    input  logic [BE_WIDTH-1:0]           in_vd,
    input  logic [BE_WIDTH-1:0]           in_vd1,
    input  logic [1:0]                    in_sew,
    input  logic [1:0]                    in_vxrm,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [DATA_WIDTH-1:0]         wb_data,
    output logic [ADDR_WIDTH-1:0]         wb_addr,
    output logic [BE_WIDTH-1:0]           wb_be,
    output logic                          wb_mask,
    output logic                          almost_full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + ADDR_WIDTH + BE_WIDTH + 1;

    function automatic logic rinc(input logic d, input logic d1,
                                  input logic [1:0] m);
        case (m)
            2'd0:    rinc = d;
            2'd1:    rinc = d & d1;
            2'd2:    rinc = 1'b0;
            default: rinc = d & ~d1;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] r_data_d;
    logic                  bypass;

    // Each element adds its own increment; the slice width bounds the carry.
    always_comb begin
        r_data_d = in_vec;
        bypass   = !in_fxp || in_mask || (in_sew == 2'd3 && !ENABLE_64_BIT);
        if (!bypass) begin
            case (in_sew)
                2'd0: for (int k = 0; k < BE_WIDTH; k++)
                    r_data_d[8*k +: 8] = in_vec[8*k +: 8]
                        + {7'd0, rinc(in_vd[k], in_vd1[k], in_vxrm)};
                2'd1: for (int k = 0; k < BE_WIDTH / 2; k++)
                    r_data_d[16*k +: 16] = in_vec[16*k +: 16]
                        + {15'd0, rinc(in_vd[2*k], in_vd1[2*k], in_vxrm)};
                2'd2: for (int k = 0; k < BE_WIDTH / 4; k++)
                    r_data_d[32*k +: 32] = in_vec[32*k +: 32]
                        + {31'd0, rinc(in_vd[4*k], in_vd1[4*k], in_vxrm)};
                default: for (int k = 0; k < BE_WIDTH / 8; k++)
                    r_data_d[64*k +: 64] = in_vec[64*k +: 64]
                        + {63'd0, rinc(in_vd[8*k], in_vd1[8*k], in_vxrm)};
            endcase
        end
    end

    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [BE_WIDTH-1:0]   r_be_q;
    logic                  r_mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_addr_q  <= '0;
            r_be_q    <= '0;
            r_mask_q  <= 1'b0;
        end else begin
            r_valid_q <= in_valid;
            r_data_q  <= r_data_d;
            r_addr_q  <= in_addr;
            r_be_q    <= in_be;
            r_mask_q  <= in_mask;
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          full, pop, push_ok, drop;
    logic [EW-1:0] head;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign wb_valid = (count_q != '0);
    assign pop     = wb_valid & wb_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = r_valid_q & (~full | pop);
    assign drop    = r_valid_q & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {r_data_q, r_addr_q, r_be_q, r_mask_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign head = wb_valid ? mem_q[rd_ptr_q] : '0;
    assign {wb_data, wb_addr, wb_be, wb_mask} = head;

    assign count       = count_q;
    assign overflow    = ovf_q;
    assign almost_full = (count_q >= CW'(FIFO_DEPTH - 2));

endmodule

// File: tb/tb_vfxp_round_wb.sv
// Scoreboard bench for vfxp_round_wb: directed rounding vectors,
// backpressure, overflow, full push/pop and mid-stream reset.
module tb_vfxp_round_wb;

    typedef struct packed {
        logic [63:0] d;
        logic [31:0] a;
        logic [7:0]  be;
        logic        m;
    } exp_t;

    logic        clk, rst;
    logic        in_valid, in_mask, in_fxp;
    logic [63:0] in_vec;
    logic [31:0] in_addr;
    logic [7:0]  in_be, in_vd, in_vd1;
    logic [1:0]  in_sew, in_vxrm;
    logic        wb_valid, wb_ready, wb_mask, almost_full, overflow;
    logic [63:0] wb_data;
    logic [31:0] wb_addr;
    logic [7:0]  wb_be;
    logic [2:0]  count;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic [31:0] addr_ctr = 32'h1000_0000;

    vfxp_round_wb dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_vec(in_vec), .in_addr(in_addr),
        .in_be(in_be), .in_mask(in_mask), .in_fxp(in_fxp),
        .in_vd(in_vd), .in_vd1(in_vd1), .in_sew(in_sew),
        .in_vxrm(in_vxrm),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_addr(wb_addr), .wb_be(wb_be), .wb_mask(wb_mask),
        .almost_full(almost_full), .overflow(overflow), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] v, input logic [7:0] vd,
                        input logic [7:0] vd1, input logic [1:0] sew,
                        input logic [1:0] vxrm, input logic fxp,
                        input logic mask, input logic [63:0] expd,
                        input bit keep);
        in_vec   = v;
        in_vd    = vd;
        in_vd1   = vd1;
        in_sew   = sew;
        in_vxrm  = vxrm;
        in_fxp   = fxp;
        in_mask  = mask;
        in_addr  = addr_ctr;
        in_be    = addr_ctr[7:0];
        in_valid = 1'b1;
        if (keep) sbq.push_back('{expd, addr_ctr, addr_ctr[7:0], mask});
        addr_ctr = addr_ctr + 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pass(input logic [63:0] v, input bit keep);
        send(v, 8'hFF, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0, v, keep);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h expected none", wb_data);
            end else begin
                mon_e = sbq.pop_front();
                chk("wb_data", wb_data, mon_e.d);
                chk("wb_addr", {32'd0, wb_addr}, {32'd0, mon_e.a});
                chk("wb_be", {56'd0, wb_be}, {56'd0, mon_e.be});
                chk("wb_mask", {63'd0, wb_mask}, {63'd0, mon_e.m});
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_addr = '0;
        in_be = '0; in_mask = 1'b0; in_fxp = 1'b0; in_vd = '0;
        in_vd1 = '0; in_sew = '0; in_vxrm = '0; wb_ready = 1'b1;
        step(2);
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_almost_full", {63'd0, almost_full}, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        rst = 1'b0;
        step(1);

        // SEW8 rnu, two-cycle latency
        send(64'h0000_0000_007F_103F, 8'h05, 8'h00, 2'd0, 2'd0, 1, 0,
             64'h0000_0000_0080_1040, 1);
        chk("latency_early", {63'd0, wb_valid}, 64'd0);
        step(1);
        chk("latency_valid", {63'd0, wb_valid}, 64'd1);
        chk("latency_data", wb_data, 64'h0000_0000_0080_1040);

        // rne, rod, rdn
        send(64'h3E3F, 8'h03, 8'h01, 2'd0, 2'd1, 1, 0, 64'h3E40, 1);
        send(64'h3E3F, 8'h03, 8'h01, 2'd0, 2'd3, 1, 0, 64'h3F3F, 1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'h00, 2'd0, 2'd2, 1, 0,
             64'hFFFF_FFFF_FFFF_FFFF, 1);
        // carry confinement
        send(64'h55FF, 8'h01, 8'h00, 2'd0, 2'd0, 1, 0, 64'h5500, 1);
        send(64'hFFFF_0000_1234_00FF, 8'h43, 8'h00, 2'd1, 2'd0, 1, 0,
             64'h0000_0000_1234_0100, 1);
        send(64'h0000_0001_FFFF_FFFF, 8'h01, 8'h00, 2'd2, 2'd0, 1, 0,
             64'h0000_0001_0000_0000, 1);
        // pass-through cases
        send(64'h0123_4567_89AB_CDEF, 8'hFF, 8'h00, 2'd0, 2'd0, 1, 1,
             64'h0123_4567_89AB_CDEF, 1);
        send(64'h0123_4567_89AB_CDEF, 8'hFF, 8'h00, 2'd0, 2'd0, 0, 0,
             64'h0123_4567_89AB_CDEF, 1);
        send(64'h0000_0000_0000_00FF, 8'h01, 8'h00, 2'd3, 2'd0, 1, 0,
             64'h0000_0000_0000_00FF, 1);
        step(4);
        chk("directed_drained", 64'(sbq.size()), 64'd0);

        // backpressure and overflow: A..E, E dropped
        wb_ready = 1'b0;
        pass(64'hAAAA, 1);
        pass(64'hBBBB, 1);
        chk("bp_count_1", {61'd0, count}, 64'd1);
        chk("bp_af_lo", {63'd0, almost_full}, 64'd0);
        pass(64'hCCCC, 1);
        chk("bp_count_2", {61'd0, count}, 64'd2);
        chk("bp_af_hi", {63'd0, almost_full}, 64'd1);
        pass(64'hDDDD, 1);
        pass(64'hEEEE, 0);
        chk("bp_no_ovf_yet", {63'd0, overflow}, 64'd0);
        step(1);
        chk("bp_count_full", {61'd0, count}, 64'd4);
        chk("bp_overflow", {63'd0, overflow}, 64'd1);
        chk("bp_hold_head", wb_data, 64'hAAAA);
        wb_ready = 1'b1;
        step(6);
        chk("bp_drained", 64'(sbq.size()), 64'd0);
        chk("bp_count_0", {61'd0, count}, 64'd0);
        chk("bp_ovf_sticky", {63'd0, overflow}, 64'd1);

        // full FIFO with simultaneous push and pop
        wb_ready = 1'b0;
        pass(64'h1111, 1);
        pass(64'h2222, 1);
        pass(64'h3333, 1);
        pass(64'h4444, 1);
        step(1);
        chk("fp_full", {61'd0, count}, 64'd4);
        pass(64'hF0F0, 1);
        wb_ready = 1'b1;
        step(1);
        wb_ready = 1'b0;
        chk("fp_count_same", {61'd0, count}, 64'd4);
        chk("fp_ovf_same", {63'd0, overflow}, 64'd1);
        wb_ready = 1'b1;
        step(6);
        chk("fp_drained", 64'(sbq.size()), 64'd0);

        // mid-stream reset
        wb_ready = 1'b0;
        pass(64'h5A5A, 1);
        step(1);
        chk("mr_count_1", {61'd0, count}, 64'd1);
        rst = 1'b1;
        in_vec = 64'h7777;
        in_valid = 1'b1;
        sbq.delete();
        step(1);
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mr_count", {61'd0, count}, 64'd0);
        chk("mr_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("mr_overflow", {63'd0, overflow}, 64'd0);
        chk("mr_almost_full", {63'd0, almost_full}, 64'd0);
        chk("mr_wb_data", wb_data, 64'd0);
        step(2);
        chk("mr_rst_beat_ignored", {63'd0, wb_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
